// File: rtl/sum_uart_tx.sv
// rtl/sum_uart_tx.sv - UART 8N1 transmitter for the adder sum, valid/ready input, clock-enable gated.
// Outputs are registered; frame length is exactly 10*CLKS_PER_BIT enabled cycles.
module sum_uart_tx #(
  parameter int unsigned CLKS_PER_BIT = 16,
  localparam int unsigned CNT_W = $clog2(CLKS_PER_BIT)
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       ena,
  input  logic [7:0] in_data,
  input  logic       in_valid,
  output logic       in_ready,
  output logic       tx,
  output logic       busy,
  output logic       frame_done
);

  if (CLKS_PER_BIT < 2 || CLKS_PER_BIT > 65535) begin : g_bad_clks_per_bit
    $error("sum_uart_tx: CLKS_PER_BIT must be in 2..65535");
  end

  typedef enum logic [1:0] {
    S_IDLE,
    S_START,
    S_DATA,
    S_STOP
  } state_t;

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CLKS_PER_BIT - 1);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [2:0]       bit_idx_q, bit_idx_d;
  logic [7:0]       shift_q, shift_d;
  logic             tx_q, tx_d;
  logic             ready_q, ready_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic             cnt_last;

  assign cnt_last = (cnt_q == CNT_LAST);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= S_IDLE;
      cnt_q     <= '0;
      bit_idx_q <= '0;
      shift_q   <= '0;
      tx_q      <= 1'b1;
      ready_q   <= 1'b1;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      bit_idx_q <= bit_idx_d;
      shift_q   <= shift_d;
      tx_q      <= tx_d;
      ready_q   <= ready_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
    end
  end

  // With ena low every register keeps its value, including a pending frame_done.
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    bit_idx_d = bit_idx_q;
    shift_d   = shift_q;
    tx_d      = tx_q;
    ready_d   = ready_q;
    busy_d    = busy_q;
    done_d    = done_q;

    if (ena) begin
      done_d = 1'b0;
      case (state_q)
        S_IDLE: begin
          tx_d = 1'b1;
          if (in_valid && ready_q) begin
            shift_d = in_data;
            state_d = S_START;
            tx_d    = 1'b0;
            cnt_d   = '0;
            ready_d = 1'b0;
            busy_d  = 1'b1;
          end
        end
        S_START: begin
          if (cnt_last) begin
            cnt_d     = '0;
            state_d   = S_DATA;
            bit_idx_d = 3'd0;
            tx_d      = shift_q[0];
          end else begin
            cnt_d = cnt_q + CNT_ONE;
          end
        end
        S_DATA: begin
          if (cnt_last) begin
            cnt_d = '0;
            if (bit_idx_q == 3'd7) begin
              state_d = S_STOP;
              tx_d    = 1'b1;
            end else begin
              bit_idx_d = bit_idx_q + 3'd1;
              shift_d   = {1'b0, shift_q[7:1]};
              tx_d      = shift_q[1];
            end
          end else begin
            cnt_d = cnt_q + CNT_ONE;
          end
        end
        S_STOP: begin
          if (cnt_last) begin
            cnt_d   = '0;
            state_d = S_IDLE;
            tx_d    = 1'b1;
            ready_d = 1'b1;
            busy_d  = 1'b0;
            done_d  = 1'b1;
          end else begin
            cnt_d = cnt_q + CNT_ONE;
          end
        end
        default: begin
          state_d = S_IDLE;
          tx_d    = 1'b1;
          ready_d = 1'b1;
          busy_d  = 1'b0;
        end
      endcase
    end
  end

  assign in_ready   = ready_q;
  assign tx         = tx_q;
  assign busy       = busy_q;
  assign frame_done = done_q;

endmodule

// File: tb/tb_sum_uart_tx.sv
// tb/tb_sum_uart_tx.sv - self-checking bench for sum_uart_tx with a frame-level reference model.
module tb_sum_uart_tx;
  localparam int C = 4;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       ena = 1'b0;
  logic [7:0] in_data = 8'h00;
  logic       in_valid = 1'b0;
  logic       in_ready, tx, busy, frame_done;

  int vectors = 0;
  int miscompares = 0;

  sum_uart_tx #(.CLKS_PER_BIT(C)) dut (
    .clk(clk), .rst_n(rst_n), .ena(ena), .in_data(in_data), .in_valid(in_valid),
    .in_ready(in_ready), .tx(tx), .busy(busy), .frame_done(frame_done)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference: a frame is just "enabled cycles since acceptance" plus the accepted byte.
  bit         m_active = 1'b0;
  int         m_t = 0;
  logic [7:0] m_byte = 8'h00;
  bit         m_done = 1'b0;
  logic [7:0] exp_q[$];

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_active <= 1'b0;
      m_t      <= 0;
      m_done   <= 1'b0;
      exp_q.delete();
    end else if (ena) begin
      if (m_active) begin
        m_t      <= m_t + 1;
        m_done   <= (m_t + 1 == 10 * C);
        m_active <= (m_t + 1 != 10 * C);
      end else begin
        m_done <= 1'b0;
        if (in_valid) begin
          m_active <= 1'b1;
          m_t      <= 0;
          m_byte   <= in_data;
          exp_q.push_back(in_data);
        end
      end
    end
  end

  function automatic logic exp_tx();
    int b;
    if (!m_active) return 1'b1;
    b = m_t / C;
    if (b == 0) return 1'b0;
    if (b <= 8) return m_byte[b-1];
    return 1'b1;
  endfunction

  always @(negedge clk) begin
    if (rst_n) begin
      check("tx", tx, exp_tx());
      check("in_ready", in_ready, !m_active);
      check("busy", busy, m_active);
      check("frame_done", frame_done, m_done);
    end
  end

  // Line decoder: mid-bit sampling over enabled cycles, bytes checked against the model's accept order.
  bit         en_seen = 1'b0;
  bit         rx_busy = 1'b0;
  int         rx_s = 0;
  int         idle_cnt = 0;
  int         last_gap = -1;
  logic [7:0] rx_byte = 8'h00;
  logic [7:0] rx_log[$];

  always @(posedge clk) en_seen <= ena;

  always @(negedge clk) begin
    logic [7:0] e;
    if (!rst_n) begin
      rx_busy  = 1'b0;
      idle_cnt = 0;
    end else if (en_seen) begin
      if (!rx_busy) begin
        if (tx == 1'b0) begin
          rx_busy  = 1'b1;
          rx_s     = 0;
          last_gap = idle_cnt;
        end else begin
          idle_cnt++;
        end
      end else begin
        rx_s++;
        if (rx_s >= C && rx_s < 9 * C && (rx_s % C) == C / 2) rx_byte[rx_s/C-1] = tx;
        if (rx_s == 9 * C + C / 2) begin
          check("stop_bit", tx, 1'b1);
          rx_log.push_back(rx_byte);
          if (exp_q.size() == 0) begin
            check("rx_unexpected_frame", 0, 1);
          end else begin
            e = exp_q.pop_front();
            check("rx_byte", rx_byte, e);
          end
        end
        if (rx_s == 10 * C - 1) begin
          rx_busy  = 1'b0;
          idle_cnt = 0;
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic send(input logic [7:0] b);
    int n = 0;
    while (!in_ready && n < 500) begin
      tick();
      n++;
    end
    check("send_timeout", (n < 500), 1);
    in_data  = b;
    in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
  endtask

  task automatic wait_idle();
    int n = 0;
    while ((!in_ready || rx_busy) && n < 2000) begin
      tick();
      n++;
    end
    check("idle_timeout", (n < 2000), 1);
    tick();
  endtask

  logic       s_tx[40];
  int         rdy_low;
  int         base;
  int         en_cnt;
  int         n;
  logic [9:0] pat;

  initial begin
    ena = 1'b1;
    tick();
    tick();
    #1;
    check("reset_tx", tx, 1'b1);
    check("reset_in_ready", in_ready, 1'b1);
    check("reset_busy", busy, 1'b0);
    check("reset_frame_done", frame_done, 1'b0);
    rst_n = 1'b1;
    tick();

    // Basic 0xA5 frame against a hand-derived line pattern (index 0 = start bit).
    pat = 10'b1101001010;
    in_data  = 8'hA5;
    in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    rdy_low = 0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      s_tx[i] = tx;
      if (!in_ready) rdy_low++;
    end
    @(negedge clk);
    check("basic_done_cycle41", frame_done, 1'b1);
    check("basic_ready_cycle41", in_ready, 1'b1);
    @(negedge clk);
    check("basic_done_cycle42", frame_done, 1'b0);
    for (int i = 0; i < 40; i++) check($sformatf("basic_tx_%0d", i), s_tx[i], pat[i/C]);
    check("basic_ready_low_cycles", rdy_low, 40);
    tick();

    // Back-to-back with in_valid held.
    base = rx_log.size();
    in_data  = 8'h3C;
    in_valid = 1'b1;
    tick();
    in_data = 8'hC3;
    repeat (41) tick();
    in_valid = 1'b0;
    check("b2b_second_accepted", in_ready, 1'b0);
    wait_idle();
    check("b2b_count", rx_log.size(), base + 2);
    if (rx_log.size() >= base + 2) begin
      check("b2b_first", rx_log[base], 8'h3C);
      check("b2b_second", rx_log[base+1], 8'hC3);
    end
    check("b2b_idle_gap", last_gap, 1);

    // A byte offered while busy is dropped.
    base = rx_log.size();
    send(8'h00);
    repeat (9) tick();
    in_data  = 8'hFF;
    in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    check("busy_reject_ready", in_ready, 1'b0);
    wait_idle();
    repeat (60) tick();
    check("busy_reject_count", rx_log.size(), base + 1);
    if (rx_log.size() >= base + 1) check("busy_reject_byte", rx_log[base], 8'h00);

    // Clock-enable stall in the middle of data bit 3.
    base = rx_log.size();
    send(8'h0F);
    repeat (18) tick();
    en_cnt = 18;
    ena = 1'b0;
    repeat (7) tick();
    ena = 1'b1;
    n = 0;
    while (!in_ready && n < 200) begin
      tick();
      en_cnt++;
      n++;
    end
    check("stall_enabled_cycles", en_cnt, 40);
    wait_idle();
    check("stall_count", rx_log.size(), base + 1);
    if (rx_log.size() >= base + 1) check("stall_byte", rx_log[base], 8'h0F);

    // Reset during data bit 5 abandons the frame.
    base = rx_log.size();
    send(8'h6B);
    repeat (26) tick();
    rst_n = 1'b0;
    #1;
    check("midreset_tx", tx, 1'b1);
    check("midreset_in_ready", in_ready, 1'b1);
    check("midreset_busy", busy, 1'b0);
    tick();
    tick();
    rst_n = 1'b1;
    tick();
    check("midreset_abandoned", rx_log.size(), base);
    send(8'h81);
    wait_idle();
    check("midreset_next_count", rx_log.size(), base + 1);
    if (rx_log.size() >= base + 1) check("midreset_next_byte", rx_log[base], 8'h81);

    // Reset with ena low and in_valid high: nothing starts until ena rises.
    base = rx_log.size();
    ena = 1'b0;
    in_data  = 8'h5A;
    in_valid = 1'b1;
    rst_n = 1'b0;
    tick();
    tick();
    rst_n = 1'b1;
    repeat (5) tick();
    check("ena_low_ready", in_ready, 1'b1);
    check("ena_low_tx", tx, 1'b1);
    ena = 1'b1;
    tick();
    in_valid = 1'b0;
    check("ena_first_edge_accept", in_ready, 1'b0);
    wait_idle();
    check("ena_byte_count", rx_log.size(), base + 1);
    if (rx_log.size() >= base + 1) check("ena_byte", rx_log[base], 8'h5A);

    // Randomized traffic with ena gaps; the per-cycle model and decoder check everything.
    for (int i = 0; i < 3000; i++) begin
      ena      = ($urandom % 8) != 0;
      in_valid = ($urandom % 3) == 0;
      in_data  = 8'($urandom);
      tick();
    end
    ena = 1'b1;
    in_valid = 1'b0;
    wait_idle();
    check("final_expect_queue_empty", exp_q.size(), 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
